// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and hazard stall
//
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded into src1/src2; only a
//               load-use dependency on the instruction held here raises stall_o.
//   undefined : src1/src2 come from the registered register-file data only; any
//               RAW dependency on this stage, EX/MEM or MEM/WB raises stall_o.
//
// Ports:
//   clk_i, rst_n                      clock (rising edge), async active-low reset
//   in_valid, rs/rt/rd_addr           decoded instruction and its register numbers
//   rs_data, rt_data, imm             register-file operands and immediate
//   alu_src, uses_rt                  src2 from imm; instruction reads rt
//   ALU_control, bonus_control        ALU operation select, passed through
//   reg_write, mem_read, flush        writeback/load flags; squash this stage
//   exmem_*, memwb_*                  destination, write enable and value of later stages
//   src1, src2                        ALU operands
//   ALU_control_o, bonus_control_o    registered operation select
//   rd_o, reg_write_o, mem_read_o     registered destination and flags
//   out_valid                         a real instruction occupies the stage
//   stall_o                           hold PC and IF/ID this cycle
//   stall_cnt                         saturating count of stalled cycles
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic        uses_rt,
  input  logic [3:0]  ALU_control,
  input  logic [2:0]  bonus_control,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        flush,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_reg_write,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_reg_write,
  input  logic [31:0] memwb_data,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [3:0]  ALU_control_o,
  output logic [2:0]  bonus_control_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        out_valid,
  output logic        stall_o,
  output logic [15:0] stall_cnt
);

  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_q;
  logic        alu_src_q;
  logic        rs_live;
  logic        rt_live;
  logic        hazard;

  // A source only creates a dependency when the incoming instruction is real,
  // actually reads it, and it is not r0.
  assign rs_live = in_valid && (rs_addr != 5'd0);
  assign rt_live = in_valid && uses_rt && (rt_addr != 5'd0);

  function automatic logic reads(input logic [4:0] r);
    return (rs_live && (r == rs_addr)) || (rt_live && (r == rt_addr));
  endfunction

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is applied last so it wins over MEM/WB on a double match.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    logic [31:0] v;
    v = d;
    if ((r != 5'd0) && memwb_reg_write && (memwb_rd == r)) v = memwb_data;
    if ((r != 5'd0) && exmem_reg_write && (exmem_rd == r)) v = exmem_result;
    return v;
  endfunction

  // Only a load here cannot be forwarded in time; everything else is covered
  // by the EX/MEM and MEM/WB paths.
  assign hazard = out_valid && mem_read_o && reads(rd_o);

  assign src1 = fwd(rs_q, rs_data_q);
  assign src2 = alu_src_q ? imm_q : fwd(rt_q, rt_data_q);
`else
  // Without forwarding the consumer waits until every in-flight producer of its
  // sources has retired.
  assign hazard = (out_valid && reg_write_o && reads(rd_o))
               || (exmem_reg_write && reads(exmem_rd))
               || (memwb_reg_write && reads(memwb_rd));

  assign src1 = rs_data_q;
  assign src2 = alu_src_q ? imm_q : rt_data_q;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_q, rt_q, exmem_result, memwb_data};
`endif

  // A flush squashes the consumer anyway, so there is nothing to hold for.
  assign stall_o = hazard && !flush;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      reg_write_o     <= 1'b0;
      mem_read_o      <= 1'b0;
      rd_o            <= 5'd0;
      rs_q            <= 5'd0;
      rt_q            <= 5'd0;
      rs_data_q       <= 32'd0;
      rt_data_q       <= 32'd0;
      imm_q           <= 32'd0;
      alu_src_q       <= 1'b0;
      ALU_control_o   <= 4'd0;
      bonus_control_o <= 3'd0;
      stall_cnt       <= 16'd0;
    end else begin
      if (flush || stall_o) begin
        // Bubble: only the fields that can have side effects are cleared.
        out_valid   <= 1'b0;
        reg_write_o <= 1'b0;
        mem_read_o  <= 1'b0;
        rd_o        <= 5'd0;
      end else begin
        out_valid       <= in_valid;
        reg_write_o     <= reg_write;
        mem_read_o      <= mem_read;
        rd_o            <= rd_addr;
        rs_q            <= rs_addr;
        rt_q            <= rt_addr;
        rs_data_q       <= rs_data;
        rt_data_q       <= rt_data;
        imm_q           <= imm;
        alu_src_q       <= alu_src;
        ALU_control_o   <= ALU_control;
        bonus_control_o <= bonus_control;
      end
      if (stall_o && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data, imm;
  logic        alu_src, uses_rt;
  logic [3:0]  ALU_control;
  logic [2:0]  bonus_control;
  logic        reg_write, mem_read, flush;
  logic [4:0]  exmem_rd;
  logic        exmem_reg_write;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;
  logic [31:0] memwb_data;
  logic [31:0] src1, src2;
  logic [3:0]  ALU_control_o;
  logic [2:0]  bonus_control_o;
  logic [4:0]  rd_o;
  logic        reg_write_o, mem_read_o, out_valid, stall_o;
  logic [15:0] stall_cnt;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n(rst_n), .in_valid(in_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_src(alu_src), .uses_rt(uses_rt),
    .ALU_control(ALU_control), .bonus_control(bonus_control),
    .reg_write(reg_write), .mem_read(mem_read), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
    .src1(src1), .src2(src2),
    .ALU_control_o(ALU_control_o), .bonus_control_o(bonus_control_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .out_valid(out_valid), .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference picture of what the stage is holding.
  logic        m_valid, m_rw, m_mr, m_alu_src;
  logic [4:0]  m_rd, m_rs, m_rt;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [3:0]  m_alu;
  logic [2:0]  m_bonus;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True when the incoming instruction reads register r.
  function automatic bit reads(input logic [4:0] r);
    return in_valid && (r != 5'd0) && ((r == rs_addr) || (uses_rt && (r == rt_addr)));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FORWARD_EN
    if (r != 5'd0 && exmem_reg_write && exmem_rd == r) return exmem_result;
    if (r != 5'd0 && memwb_reg_write && memwb_rd == r) return memwb_data;
`endif
    return d;
  endfunction

  function automatic bit want_stall();
    if (flush) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return m_valid && m_mr && reads(m_rd);
`else
    return (m_valid && m_rw && reads(m_rd))
        || (exmem_reg_write && reads(exmem_rd))
        || (memwb_reg_write && reads(memwb_rd));
`endif
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_alu_src = 0;
    m_rd = 0; m_rs = 0; m_rt = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_alu = 0; m_bonus = 0; m_cnt = 0;
  endtask

  task automatic check_regs();
    check("out_valid", out_valid, m_valid);
    check("reg_write_o", reg_write_o, m_rw);
    check("mem_read_o", mem_read_o, m_mr);
    check("rd_o", rd_o, m_rd);
    check("stall_cnt", stall_cnt, m_cnt);
    if (m_valid) begin
      check("ALU_control_o", ALU_control_o, m_alu);
      check("bonus_control_o", bonus_control_o, m_bonus);
    end
  endtask

  // Starts and ends on a falling edge; inputs are already applied.
  task automatic cycle();
    bit st;
    #1;
    st = want_stall();
    check("stall_o", stall_o, st);
    if (m_valid) begin
      check("src1", src1, operand(m_rs, m_rs_data));
      check("src2", src2, m_alu_src ? m_imm : operand(m_rt, m_rt_data));
    end
    @(posedge clk_i);
    if (flush || st) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_rd = 0;
    end else begin
      m_valid = in_valid; m_rw = reg_write; m_mr = mem_read; m_rd = rd_addr;
      m_rs = rs_addr; m_rt = rt_addr; m_rs_data = rs_data; m_rt_data = rt_data;
      m_imm = imm; m_alu_src = alu_src; m_alu = ALU_control; m_bonus = bonus_control;
    end
    if (st && m_cnt < 65535) m_cnt++;
    #1;
    check_regs();
    @(negedge clk_i);
  endtask

  task automatic quiet_fwd();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, im,
                       input logic asrc, urt, rw, mr, input logic [3:0] alu, input logic [2:0] bon);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = im; alu_src = asrc; uses_rt = urt;
    reg_write = rw; mem_read = mr; ALU_control = alu; bonus_control = bon;
  endtask

  // Called on a falling edge; asserts reset between edges and releases on a falling edge.
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_clear();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_rd_o", rd_o, 0);
    check("rst_reg_write_o", reg_write_o, 0);
    check("rst_mem_read_o", mem_read_o, 0);
    check("rst_ALU_control_o", ALU_control_o, 0);
    check("rst_bonus_control_o", bonus_control_o, 0);
    check("rst_src1", src1, 0);
    check("rst_src2", src2, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_stall_cnt", stall_cnt, 0);
    @(negedge clk_i);
    rst_n = 1;
  endtask

  int saved_cnt;

  initial begin
    rst_n = 1; flush = 0;
    in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
    rs_data = 0; rt_data = 0; imm = 0; alu_src = 0; uses_rt = 0;
    ALU_control = 0; bonus_control = 0; reg_write = 0; mem_read = 0;
    quiet_fwd();
    model_clear();
    @(negedge clk_i);
    do_reset();

    // Load-use: lw r5 then add reading r5.
    issue(5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1, 4'd2, 3'd0);
    cycle();
    issue(5'd5, 5'd6, 5'd7, 32'hAAAA, 32'h6666, 32'h0, 0, 1, 1, 0, 4'd7, 3'd3);
    cycle();
    check("loaduse_stall_cnt", stall_cnt, 1);
    check("loaduse_bubble", out_valid, 0);
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h1111;
    cycle();
    exmem_reg_write = 0; memwb_rd = 5; memwb_reg_write = 1; memwb_data = 32'hCAFE;
    in_valid = 0;
    cycle();

    // EX/MEM beats MEM/WB on a double match.
    quiet_fwd();
    issue(5'd3, 5'd4, 5'd8, 32'h33, 32'h44, 32'h0, 0, 1, 1, 0, 4'd1, 3'd0);
    cycle();
    in_valid = 0;
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h11;
    memwb_rd = 3; memwb_reg_write = 1; memwb_data = 32'h22;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("prio_exmem", src1, 32'h11);
`else
    check("prio_exmem", src1, 32'h33);
`endif
    exmem_reg_write = 0;
    #1;
`ifdef ID_EX_FORWARD_EN
    check("prio_memwb", src1, 32'h22);
`else
    check("prio_memwb", src1, 32'h33);
`endif
    cycle();

    // r0 is never forwarded.
    quiet_fwd();
    issue(5'd0, 5'd0, 5'd10, 32'hBEEF, 32'h0, 32'h0, 0, 1, 1, 0, 4'd3, 3'd1);
    cycle();
    in_valid = 0;
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hDEAD;
    memwb_rd = 0; memwb_reg_write = 1; memwb_data = 32'h5555;
    #1;
    check("r0_no_forward", src1, 32'hBEEF);
    cycle();

    // Flush overrides a load-use stall.
    quiet_fwd();
    issue(5'd2, 5'd0, 5'd9, 32'h20, 32'h0, 32'h8, 1, 0, 1, 1, 4'd2, 3'd0);
    cycle();
    issue(5'd9, 5'd1, 5'd11, 32'h90, 32'h10, 32'h0, 0, 1, 1, 0, 4'd0, 3'd0);
    flush = 1;
    saved_cnt = m_cnt;
    cycle();
    check("flush_cnt_kept", stall_cnt, saved_cnt);
    check("flush_bubble", out_valid, 0);
    flush = 0;

    // Reset in the middle of a stall drops the stalled instruction.
    issue(5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1, 4'd2, 3'd0);
    cycle();
    issue(5'd5, 5'd6, 5'd12, 32'h55, 32'h66, 32'h0, 0, 1, 1, 0, 4'd5, 3'd2);
    #1;
    check("midstall_stall_o", stall_o, 1);
    do_reset();
    cycle();
    check("after_reset_capture", out_valid, 1);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      rs_data = $urandom; rt_data = $urandom; imm = $urandom;
      alu_src = 1'($urandom_range(0, 1)); uses_rt = 1'($urandom_range(0, 1));
      ALU_control = 4'($urandom_range(0, 15)); bonus_control = 3'($urandom_range(0, 7));
      reg_write = 1'($urandom_range(0, 1)); mem_read = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_data = $urandom;
      cycle();
    end
    flush = 0;

`ifndef ID_EX_FORWARD_EN
    // Saturation: a producer parked in EX/MEM keeps the consumer stalled.
    in_valid = 0; quiet_fwd();
    do_reset();
    issue(5'd5, 5'd0, 5'd6, 32'h1, 32'h2, 32'h3, 0, 0, 1, 0, 4'd1, 3'd0);
    exmem_rd = 5; exmem_reg_write = 1;
    repeat (65534) @(posedge clk_i);
    #1;
    check("sat_fffe", stall_cnt, 16'hFFFE);
    @(posedge clk_i);
    #1;
    check("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk_i);
    #1;
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_stall_o", stall_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid  in  1  decoded instruction present; rs_addr/rt_addr/rd_addr  in  5 each; rs_data/rt_data/imm  in  32 each; alu_src  in  1  (1 = src2 from imm); uses_rt  in  1.
REQ-004 SHALL have: ALU_control  in  4; bonus_control  in  3; reg_write  in  1; mem_read  in  1; flush  in  1.
REQ-005 SHALL have: exmem_rd  in  5; exmem_reg_write  in  1; exmem_result  in  32; memwb_rd  in  5; memwb_reg_write  in  1; memwb_data  in  32.
REQ-006 SHALL have: src1/src2  out  32  ALU operands; ALU_control_o  out  4; bonus_control_o  out  3; rd_o  out  5; reg_write_o/mem_read_o/out_valid  out  1; stall_o  out  1 (hold PC and IF/ID); stall_cnt  out  16.

Function
REQ-007 SHALL register in_valid, rs/rt/rd addr, rs/rt data, imm, alu_src, ALU_control, bonus_control, reg_write, mem_read each rising edge when stall_o=0 and flush=0.
REQ-008 SHALL, when stall_o=1 and flush=0, load a bubble: out_valid=0, reg_write_o=0, mem_read_o=0, rd_o=0; other fields don't-care.
REQ-009 SHALL, when flush=1, load a bubble regardless of stall; flush SHALL force stall_o=0 that cycle.
REQ-010 SHALL assert stall_o combinationally (load-use) when out_valid=1, mem_read_o=1, rd_o!=0, in_valid=1 and (rd_o==rs_addr or (uses_rt=1 and rd_o==rt_addr)).
REQ-011 SHALL derive src1 = forwarded(rs_q) and src2 = alu_src_q ? imm_q : forwarded(rt_q), combinational from registered fields and current forwarding inputs.
REQ-012 SHALL forward per register r: exmem_result if exmem_reg_write=1, exmem_rd!=0, exmem_rd==r; else memwb_data if memwb_reg_write=1, memwb_rd!=0, memwb_rd==r; else registered data. EX/MEM wins over MEM/WB on double match.
REQ-013 SHALL never forward register 0; src for r=0 is registered data.
REQ-014 SHALL pass ALU_control_o and bonus_control_o unchanged (4 and 3 bits); code 7 with bonus_control selects compare forms.
REQ-015 SHALL increment stall_cnt by 1 on each edge where stall_o=1, saturating at 16'hFFFF (no wrap).
REQ-016 SHALL give one-cycle latency: instruction accepted at edge N appears on outputs after edge N.
REQ-017 SHALL, on a back-to-back load-use, stall exactly one cycle; the stalled instruction is captured on the next edge with src from MEM/WB forwarding.

Reset
REQ-018 SHALL, on rst_n=0, immediately clear all registers: out_valid=0, reg_write_o=0, mem_read_o=0, rd_o=0, ALU_control_o=0, bonus_control_o=0, all stored data/imm=0, stall_cnt=0.
REQ-019 SHALL hold reset state while rst_n=0 irrespective of clk_i; reset mid-stall drops the stalled instruction; first capture on first edge after release.

Configuration
REQ-020 SHALL use macro ID_EX_FORWARD_EN: defined -> REQ-010..013 forwarding and load-use stall as stated.
REQ-021 SHALL, with ID_EX_FORWARD_EN undefined, drive src1/src2 from registered data only, and assert stall_o for any RAW hazard: in_valid=1 and a nonzero source (rs, or rt when uses_rt) matching rd_o (out_valid & reg_write_o), exmem_rd (exmem_reg_write) or memwb_rd (memwb_reg_write); REQ-008/009/015 unchanged.

Verification
REQ-022 Reset: rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, stall_cnt=0 immediately, no clock.
REQ-023 Forward priority: rs_q=3, exmem_rd=3 result 32'h11, memwb_rd=3 data 32'h22 -> src1=32'h11; clear exmem_reg_write -> src1=32'h22.
REQ-024 Load-use: lw r5 in stage, next in_valid add rs=5 -> stall_o=1 one cycle, bubble out, stall_cnt=1, add issued next edge with src1=memwb_data.
REQ-025 Register 0: rs_q=0, exmem_rd=0, exmem_reg_write=1, result 32'hDEAD -> src1=stored rs_data, no forward.
REQ-026 Flush with hazard: load-use condition plus flush=1 -> stall_o=0, next out_valid=0, stall_cnt unchanged.
REQ-027 Saturation: force 65 536 stall cycles -> stall_cnt holds 16'hFFFF.
